// File: rtl/button_event_conditioner.sv
// -----------------------------------------------------------------------------
// button_event_conditioner
//
// Purpose:
//   Front-end conditioning for the five launchpad buttons (four pads plus the
//   mode button). Each raw, asynchronous, active-high button is synchronised,
//   debounced and tracked by a small press/release FSM. Each channel emits
//   exactly one single-cycle event pulse per debounced press. Releases and
//   bounce never produce a pulse.
//
// Ports:
//   clk       in   1  system clock, rising edge
//   rst       in   1  asynchronous, active-low reset
//   btn_raw   in   5  raw buttons; [0..3] = pads 1..4, [4] = mode
//   en        in   1  1 = pulses enabled; 0 = FSMs keep tracking, events held 0
//   event_1   out  1  registered 1-cycle pulse, debounced press of btn_raw[0]
//   event_2   out  1  same for btn_raw[1]
//   event_3   out  1  same for btn_raw[2]
//   event_4   out  1  same for btn_raw[3]
//   event_10  out  1  same for btn_raw[4]
//   btn_held  out  5  registered debounced level per channel
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive stable synced cycles needed to accept an edge (>= 2)
//   CNT_W            debounce counter width, must hold DEBOUNCE_CYCLES
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// button_event_channel
//
// Purpose:
//   One conditioning channel: 2-FF synchroniser, debounce counter and
//   press/release FSM with registered event pulse and held level.
//
// Ports:
//   clk      in   1  system clock
//   rst      in   1  asynchronous, active-low reset
//   i_raw    in   1  raw asynchronous button level
//   i_en     in   1  event enable, sampled only when a press is accepted
//   o_event  out  1  registered single-cycle press event
//   o_held   out  1  registered debounced level (HELD or REL_CHK)
// -----------------------------------------------------------------------------
module button_event_channel #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  input  logic i_en,
  output logic o_event,
  output logic o_held
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PRESS_CHK = 2'd1,
    ST_HELD      = 2'd2,
    ST_REL_CHK   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LP_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] LP_CNT_ONE = CNT_W'(1);

  // Synchroniser
  logic r_sync_1;
  logic r_sync_2;
  logic w_s;

  // FSM and counter
  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;

  // Output path
  logic w_accept;
  logic w_event_next;
  logic w_held_next;
  logic r_event;
  logic r_held;

  // Two-flop synchroniser; only r_sync_2 is used by downstream logic.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync_1 <= 1'b0;
      r_sync_2 <= 1'b0;
    end else begin
      r_sync_1 <= i_raw;
      r_sync_2 <= r_sync_1;
    end
  end

  assign w_s = r_sync_2;

  // State register (the debounce counter travels with the state).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next-state logic. The counter counts consecutive cycles of the candidate
  // level including the cycle that entered the check state, so the check
  // completes once it has reached DEBOUNCE_CYCLES and then seen one more
  // stable cycle. The >= comparison keeps the counter from ever wrapping.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_s) begin
          w_state_next = ST_PRESS_CHK;
          w_cnt_next   = LP_CNT_ONE;
        end else begin
          w_cnt_next   = '0;
        end
      end
      ST_PRESS_CHK: begin
        if (!w_s) begin
          w_state_next = ST_IDLE;
          w_cnt_next   = '0;
        end else if (r_cnt < LP_CNT_MAX) begin
          w_cnt_next   = r_cnt + LP_CNT_ONE;
        end else begin
          w_state_next = ST_HELD;
          w_cnt_next   = '0;
        end
      end
      ST_HELD: begin
        if (!w_s) begin
          w_state_next = ST_REL_CHK;
          w_cnt_next   = LP_CNT_ONE;
        end
      end
      ST_REL_CHK: begin
        if (w_s) begin
          w_state_next = ST_HELD;
          w_cnt_next   = '0;
        end else if (r_cnt < LP_CNT_MAX) begin
          w_cnt_next   = r_cnt + LP_CNT_ONE;
        end else begin
          w_state_next = ST_IDLE;
          w_cnt_next   = '0;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Output logic. The pulse is generated only on the PRESS_CHK->HELD
  // transition, so a press accepted while disabled is consumed and never
  // replayed when the enable later rises. The held level is taken from the
  // next state so it rises on the same edge as the pulse.
  always_comb begin
    w_accept     = (r_state == ST_PRESS_CHK) && w_s && (r_cnt >= LP_CNT_MAX);
    w_event_next = w_accept && i_en;
    w_held_next  = (w_state_next == ST_HELD) || (w_state_next == ST_REL_CHK);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_event <= 1'b0;
      r_held  <= 1'b0;
    end else begin
      r_event <= w_event_next;
      r_held  <= w_held_next;
    end
  end

  assign o_event = r_event;
  assign o_held  = r_held;

endmodule

module button_event_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] btn_raw,
  input  logic       en,
  output logic       event_1,
  output logic       event_2,
  output logic       event_3,
  output logic       event_4,
  output logic       event_10,
  output logic [4:0] btn_held
);

  logic [4:0] w_event;
  logic [4:0] w_held;

  // Five identical, fully independent channels; simultaneous presses pulse
  // in the same cycle and are left for downstream logic to combine.
  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_channel
      button_event_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
      ) u_channel (
        .clk     (clk),
        .rst     (rst),
        .i_raw   (btn_raw[gi]),
        .i_en    (en),
        .o_event (w_event[gi]),
        .o_held  (w_held[gi])
      );
    end
  endgenerate

  assign event_1  = w_event[0];
  assign event_2  = w_event[1];
  assign event_3  = w_event[2];
  assign event_4  = w_event[3];
  assign event_10 = w_event[4];
  assign btn_held = w_held;

endmodule
